// File: rtl/uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_packer
// Purpose  : Packs pairs of UART bytes (high byte first) into 16-bit words and
//            queues them in a first-word-fall-through FIFO for the CPU side.
//            Optional feature macro: UART_RX_PACKER_TIMEOUT_EN -- discards a
//            lone high byte when the low byte does not arrive in time.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_packer #(
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_RxDone,
  input  logic [7:0]            i_RxD,
  input  logic                  i_rd,
  input  logic                  i_clr_ovr,
  output logic [15:0]           o_word,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overrun,
  output logic                  o_timeout
);

  localparam int unsigned        c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [0:0] {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            hi_byte_q, hi_byte_d;
  logic                  rxdone_q;
  // Blocks a byte event on the first cycle after reset when i_RxDone was
  // already high while reset was asserted; once i_RxDone is seen low it stays set.
  logic                  armed_q, armed_d;
  logic [15:0]           mem_q [c_depth];
  logic [15:0]           mem_d [c_depth];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
`ifdef UART_RX_PACKER_TIMEOUT_EN
  logic [15:0]           to_cnt_q, to_cnt_d;
`else
  logic                  unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  logic        w_byte_ev;
  logic        w_word_done;
  logic [15:0] w_word;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovr_set;

  // Rising-edge detect on the receiver's done level; held-high cycles are ignored.
  assign w_byte_ev = i_RxDone & ~rxdone_q & armed_q;
  assign w_word    = {hi_byte_q, i_RxD};
  assign w_full    = (count_q == c_full_count);

  assign o_word    = mem_q[rptr_q];
  assign o_empty   = (count_q == '0);
  assign o_full    = w_full;
  assign o_count   = count_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;

  // Byte-pairing state machine: next state, held high byte and timeout counter.
  always_comb begin
    state_d     = state_q;
    hi_byte_d   = hi_byte_q;
    timeout_d   = 1'b0;
    w_word_done = 1'b0;
    armed_d     = armed_q | ~i_RxDone;
`ifdef UART_RX_PACKER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      S_HI: begin
        if (w_byte_ev) begin
          hi_byte_d = i_RxD;
          state_d   = S_LO;
`ifdef UART_RX_PACKER_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      S_LO: begin
        // A byte arriving on the expiry cycle still completes the word.
        if (w_byte_ev) begin
          w_word_done = 1'b1;
          state_d     = S_HI;
        end
`ifdef UART_RX_PACKER_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          state_d   = S_HI;
          hi_byte_d = '0;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = S_HI;
    endcase
  end

  // Word FIFO: push/pop arbitration, pointer wrap, occupancy and overrun flag.
  always_comb begin
    w_pop     = i_rd & (count_q != '0);
    w_push    = w_word_done & (~w_full | w_pop);
    w_ovr_set = w_word_done & w_full & ~w_pop;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_push) begin
      mem_d[wptr_q] = w_word;
      wptr_d        = wptr_q + 1'b1;
    end
    if (w_pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh overrun takes priority over a clear in the same cycle.
    overrun_d = w_ovr_set | (overrun_q & ~i_clr_ovr);
  end

  // State register for the pairing FSM, edge detector and FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HI;
      hi_byte_q <= '0;
      rxdone_q  <= 1'b0;
      armed_q   <= ~i_RxDone;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= '0;
      end
`ifdef UART_RX_PACKER_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      rxdone_q  <= i_RxDone;
      armed_q   <= armed_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      mem_q     <= mem_d;
`ifdef UART_RX_PACKER_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_packer
// Purpose  : Self-checking bench for uart_rx_packer. A queue-based reference
//            model tracks the expected FIFO contents and flags; a compare
//            process checks every cycle, and directed scenarios pin literals.
//            Honours UART_RX_PACKER_TIMEOUT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_packer;

  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int          TIMEOUT    = 10;
`ifdef UART_RX_PACKER_TIMEOUT_EN
  localparam bit          TO_EN      = 1'b1;
`else
  localparam bit          TO_EN      = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                i_RxDone;
  logic [7:0]          i_RxD;
  logic                i_rd;
  logic                i_clr_ovr;
  logic [15:0]         o_word;
  logic                o_empty;
  logic                o_full;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overrun;
  logic                o_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx_packer #(
    .DEPTH_LOG2     (DEPTH_LOG2),
    .TIMEOUT_CYCLES (16'd10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_RxDone  (i_RxDone),
    .i_RxD     (i_RxD),
    .i_rd      (i_rd),
    .i_clr_ovr (i_clr_ovr),
    .o_word    (o_word),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_count   (o_count),
    .o_overrun (o_overrun),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  logic [7:0]  m_hi;
  logic [15:0] m_w;
  bit          m_have_hi, m_ovr, m_to, m_prev_rx, m_ev, m_done, m_pop, m_ovr_set;
  bit          m_rst_seen = 1'b0;
  bit          m_word_zero;
  int          m_cyc = 0;
  int          m_hi_cyc;

  // Model advances on each rising edge using the inputs the DUT samples there.
  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_q.delete();
      m_have_hi   = 1'b0;
      m_ovr       = 1'b0;
      m_to        = 1'b0;
      m_prev_rx   = i_RxDone;
      m_rst_seen  = 1'b1;
      m_word_zero = 1'b1;
    end else begin
      m_ev      = i_RxDone && !m_prev_rx;
      m_prev_rx = i_RxDone;
      m_done    = 1'b0;
      m_to      = 1'b0;
      if (!m_have_hi) begin
        if (m_ev) begin
          m_hi      = i_RxD;
          m_have_hi = 1'b1;
          m_hi_cyc  = m_cyc;
        end
      end else if (m_ev) begin
        m_w       = {m_hi, i_RxD};
        m_have_hi = 1'b0;
        m_done    = 1'b1;
      end else if (TO_EN && (m_cyc - m_hi_cyc == TIMEOUT)) begin
        m_have_hi = 1'b0;
        m_to      = 1'b1;
      end
      m_pop = i_rd && (m_q.size() > 0);
      if (m_pop) void'(m_q.pop_front());
      m_ovr_set = 1'b0;
      if (m_done) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(m_w);
          m_word_zero = 1'b0;
        end else begin
          m_ovr_set = 1'b1;
        end
      end
      m_ovr = m_ovr_set || (m_ovr && !i_clr_ovr);
    end
  end

  // Compare process: every cycle, shortly after the rising edge.
  always @(posedge clk) begin
    #1;
    if (m_rst_seen) begin
      check("empty",   32'(o_empty),   32'(m_q.size() == 0));
      check("full",    32'(o_full),    32'(m_q.size() == DEPTH));
      check("count",   32'(o_count),   32'(m_q.size()));
      check("overrun", 32'(o_overrun), 32'(m_ovr));
      check("timeout", 32'(o_timeout), 32'(m_to));
      if (m_q.size() > 0)   check("word", 32'(o_word), 32'(m_q[0]));
      else if (m_word_zero) check("word_rst", 32'(o_word), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    i_RxDone = 1'b1;
    i_RxD    = b;
    tick(hold);
    i_RxDone = 1'b0;
    tick(1);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1);
    send_byte(w[7:0], 1);
  endtask

  task automatic pop_check(input logic [15:0] exp);
    check("fifo_order", 32'(o_word), 32'(exp));
    i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_empty",   32'(o_empty),   1);
    check("rst_full",    32'(o_full),    0);
    check("rst_count",   32'(o_count),   0);
    check("rst_word",    32'(o_word),    0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_timeout", 32'(o_timeout), 0);
  endtask

  int p_rx, p_rd;

  initial begin
    reset = 1'b1; i_RxDone = 1'b0; i_RxD = '0; i_rd = 1'b0; i_clr_ovr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_reset_outputs();

    // Basic pair A5,3C then a single pop
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    check("pair_word",  32'(o_word),  'hA53C);
    check("pair_count", 32'(o_count), 1);
    check("pair_empty", 32'(o_empty), 0);
    i_rd = 1'b1; tick(1); i_rd = 1'b0;
    check("pop_empty", 32'(o_empty), 1);
    check("pop_count", 32'(o_count), 0);

    // Long RxDone level counts as one byte
    send_byte(8'h12, 5);
    send_byte(8'h34, 1);
    check("level_word",  32'(o_word),  'h1234);
    check("level_count", 32'(o_count), 1);
    pop_check(16'h1234);

    // Overflow: five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_word(16'(i));
    check("ovf_full",    32'(o_full),    1);
    check("ovf_overrun", 32'(o_overrun), 1);
    check("ovf_count",   32'(o_count),   4);
    for (int i = 1; i <= 4; i++) pop_check(16'(i));
    check("ovf_drained", 32'(o_empty), 1);
    i_clr_ovr = 1'b1; tick(1); i_clr_ovr = 1'b0;
    check("clr_overrun", 32'(o_overrun), 0);

    // Full FIFO with word completion and pop on the same cycle
    for (int i = 1; i <= 4; i++) send_word(16'(i));
    send_byte(8'h00, 1);
    i_RxDone = 1'b1; i_RxD = 8'h05; i_rd = 1'b1;
    tick(1);
    i_RxDone = 1'b0; i_rd = 1'b0;
    tick(1);
    check("simul_count",   32'(o_count),   4);
    check("simul_overrun", 32'(o_overrun), 0);
    for (int i = 2; i <= 5; i++) pop_check(16'(i));
    check("simul_drained", 32'(o_empty), 1);

    // Partial word followed by silence
    send_byte(8'hFF, 1);
`ifdef UART_RX_PACKER_TIMEOUT_EN
    tick(8);
    check("to_before", 32'(o_timeout), 0);
    tick(1);
    check("to_pulse",  32'(o_timeout), 1);
    check("to_empty",  32'(o_empty),   1);
    tick(1);
    check("to_after",  32'(o_timeout), 0);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    check("to_next_word", 32'(o_word), 'h0102);
    pop_check(16'h0102);
`else
    tick(10);
    check("no_to", 32'(o_timeout), 0);
    send_byte(8'h01, 1);
    check("no_to_word", 32'(o_word), 'hFF01);
    pop_check(16'hFF01);
`endif

    // Reset in the middle of a word
    send_byte(8'h77, 1);
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    check_reset_outputs();
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("mid_rst_word",  32'(o_word),  'h1122);
    check("mid_rst_count", 32'(o_count), 1);
    pop_check(16'h1122);

    // RxDone already high across reset release gives no byte
    i_RxDone = 1'b1; i_RxD = 8'hAB;
    reset = 1'b1; tick(2); reset = 1'b0; tick(3);
    i_RxDone = 1'b0; tick(1);
    check("held_rst_empty", 32'(o_empty), 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("held_rst_word",  32'(o_word),  'h1122);
    check("held_rst_count", 32'(o_count), 1);
    pop_check(16'h1122);

    // Randomised phases: busy/quiet receiver, varying read pressure
    for (int ph = 0; ph < 40; ph++) begin
      p_rx = ($urandom_range(0, 1) == 1) ? 50 : 3;
      p_rd = $urandom_range(0, 40);
      for (int k = 0; k < 25; k++) begin
        i_RxDone  = ($urandom_range(0, 99) < p_rx);
        i_RxD     = 8'($urandom);
        i_rd      = ($urandom_range(0, 99) < p_rd);
        i_clr_ovr = ($urandom_range(0, 99) < 4);
        reset     = ($urandom_range(0, 999) < 3);
        tick(1);
      end
    end

    reset = 1'b0; i_RxDone = 1'b0; i_rd = 1'b0; i_clr_ovr = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2, word-FIFO depth = 2**DEPTH_LOG2 entries.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd50000, maximum clk cycles allowed between high and low byte.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_RxDone  input  1  byte-received flag from UART receiver; level, may stay high several cycles.
REQ-006 i_RxD  input  8  received byte; valid while i_RxDone high.
REQ-007 i_rd  input  1  pop strobe from CPU side, one word per cycle high.
REQ-008 i_clr_ovr  input  1  clears sticky overrun flag.
REQ-009 o_word  output  16  head word of FIFO (first-word-fall-through).
REQ-010 o_empty  output  1  FIFO holds no words.
REQ-011 o_full  output  1  FIFO holds 2**DEPTH_LOG2 words.
REQ-012 o_count  output  DEPTH_LOG2+1  number of stored words.
REQ-013 o_overrun  output  1  sticky: a completed word was dropped because FIFO was full.
REQ-014 o_timeout  output  1  one-cycle pulse: partial word discarded by timeout.

Function
REQ-015 Byte event = i_RxDone high in current cycle and low in previous cycle (registered edge detect); further high cycles are ignored.
REQ-016 FSM states: S_HI (waiting high byte), S_LO (high byte held, waiting low byte).
REQ-017 S_HI + byte event: latch i_RxD as high byte, go S_LO, clear timeout counter.
REQ-018 S_LO + byte event: form word {high byte, i_RxD}, write to FIFO on the same clock edge, go S_HI.
REQ-019 Latency: o_empty deasserts and o_word is valid immediately after the clock edge that samples the low-byte event (empty FIFO case).
REQ-020 FIFO ordering strictly first-in first-out; read/write pointers wrap modulo 2**DEPTH_LOG2.
REQ-021 i_rd with o_empty high: ignored, no pointer or count change.
REQ-022 Word completion with o_full high and no simultaneous pop: word dropped, o_overrun set, FIFO unchanged.
REQ-023 Word completion with o_full high and i_rd high in the same cycle: pop and push both occur, o_count stays full, no overrun.
REQ-024 Simultaneous push and pop when not full/empty: o_count unchanged.
REQ-025 i_clr_ovr clears o_overrun; if an overrun occurs in the same cycle, set wins.
REQ-026 o_word holds last head value when empty (don't-care to verification beyond reset value).

Reset
REQ-027 On reset: FSM to S_HI, held high byte discarded, pointers and o_count to 0, o_empty=1, o_full=0, o_overrun=0, o_timeout=0, o_word=16'h0000, edge-detect register=0, timeout counter=0.
REQ-028 Reset asserted mid-word or with FIFO non-empty discards all data; first byte event after reset is treated as a high byte.
REQ-029 An i_RxDone already high when reset releases does not produce a byte event until it falls and rises again.

Configuration
REQ-030 Macro UART_RX_PACKER_TIMEOUT_EN defined: in S_LO a counter increments each cycle without byte event; at TIMEOUT_CYCLES it returns to S_HI, discards high byte, pulses o_timeout for one cycle; a byte event on the expiry cycle completes the word instead (byte wins).
REQ-031 Macro undefined: no counter logic; S_LO waits indefinitely; o_timeout tied to 0.

Verification
REQ-032 Bytes 8'hA5 then 8'h3C (RxDone 1-cycle pulses) -> o_empty falls, o_word=16'hA53C, o_count=1; i_rd one cycle -> o_empty=1, o_count=0.
REQ-033 RxDone held high 5 cycles with i_RxD=8'h12, then pulse 8'h34 -> exactly one word 16'h1234 stored.
REQ-034 DEPTH_LOG2=2: write 5 words 16'h0001..16'h0005 without reads -> o_full=1, o_overrun=1, reads return 0001..0004 in order; i_clr_ovr -> o_overrun=0.
REQ-035 FIFO full, 5th word completes in same cycle as i_rd -> o_count stays 4, o_overrun stays 0, order 0002..0005.
REQ-036 TIMEOUT_EN, TIMEOUT_CYCLES=10: byte 8'hFF then silence 10 cycles -> o_timeout one-cycle pulse, FIFO empty; next bytes 8'h01,8'h02 -> word 16'h0102.
REQ-037 Reset asserted after high byte 8'h77 received -> all outputs at reset values; next bytes 8'h11,8'h22 -> word 16'h1122.
